// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the inter-stage skid register: occupancy states and the
// pipeline-wide flush command encoding.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_FULL  = 2'd1,
    SKID_SKID  = 2'd2
  } skid_state_t;

  // Two-bit encoding leaves room for future commands; unknown codes act as continue.
  typedef enum logic [1:0] {
    RESET_CONTINUE = 2'd0,
    RESET_RESET    = 2'd1
  } reset_t;

  function automatic logic is_flush(input reset_t cmd);
    return (cmd == RESET_RESET);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous reset and clear, reusable by any
// performance counter that must not wrap.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise increment until all ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register with valid/ready handshake and a two-entry skid buffer;
// in_ready is registered so downstream stalls never reach upstream combinationally.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned     WIDTH         = 64,
  parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0,
  parameter int unsigned     CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  reset_t           flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic push_s;
  logic pop_s;
  logic flush_s;
  logic stall_s;

  assign push_s  = in_valid && in_ready_q;
  assign pop_s   = out_valid_q && out_ready;
  assign flush_s = is_flush(flush);
  assign stall_s = out_valid_q && !out_ready;

  // Occupancy transitions; the skid entry is only ever filled while main is stalled.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_s) begin
      state_d = SKID_EMPTY;
      main_d  = RESET_PAYLOAD;
      skid_d  = RESET_PAYLOAD;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (push_s) begin
            state_d = SKID_FULL;
            main_d  = in_data;
          end else begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (push_s && pop_s) begin
            main_d = in_data;
          end else if (push_s) begin
            state_d = SKID_SKID;
            skid_d  = in_data;
          end else if (pop_s) begin
            state_d = SKID_EMPTY;
            main_d  = RESET_PAYLOAD;
          end else begin
            state_d = SKID_FULL;
          end
        end
        SKID_SKID: begin
          if (pop_s) begin
            state_d = SKID_FULL;
            main_d  = skid_q;
          end else begin
            state_d = SKID_SKID;
          end
        end
        default: begin
          state_d = SKID_EMPTY;
          main_d  = RESET_PAYLOAD;
          skid_d  = RESET_PAYLOAD;
        end
      endcase
    end
    in_ready_d  = (state_d != SKID_SKID);
    out_valid_d = (state_d != SKID_EMPTY);
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SKID_EMPTY;
      main_q      <= RESET_PAYLOAD;
      skid_q      <= RESET_PAYLOAD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (stall_s),
    .count (stall_cnt)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_bubble = !out_valid_q;
  assign out_data   = main_q;

endmodule
